bin2bcd_seq: RTL

Sequential binary-to-BCD converter that sits directly downstream of the free-running counter. It converts the WIDTH-bit count into packed BCD digits for the seven-segment display driver. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock, with a simple valid/ready input handshake and a one-cycle output strobe.

---
 rtl/bin2bcd_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Accepts a value over a valid/ready handshake and strobes out_valid when the packed BCD result is ready.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    bin,
    output logic                in_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic                out_valid,
    output logic                overflow
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] shift_reg;
    logic [SW-1:0] adjusted;
    logic [SW-1:0] shifted;
    logic [CW-1:0] bit_cnt_reg;
    logic          ovf_reg;
    logic          ovf_next;
    logic [BW-1:0] bcd_reg;
    logic          overflow_reg;
    logic          accept;
    logic          last_bit;

    assign accept   = (state_reg == IDLE) && in_valid;
    assign last_bit = (bit_cnt_reg == CW'(1));

    // Binary part passes through; each digit field is adjusted on its own, no carry between fields.
    assign adjusted[WIDTH-1:0] = shift_reg[WIDTH-1:0];
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            localparam int LO = WIDTH + 4 * gi;
            assign adjusted[LO +: 4] = (shift_reg[LO +: 4] >= 4'd5) ? (shift_reg[LO +: 4] + 4'd3)
                                                                     : shift_reg[LO +: 4];
        end
    endgenerate

    assign shifted  = {adjusted[SW-2:0], 1'b0};
    assign ovf_next = ovf_reg | adjusted[SW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            ovf_reg      <= 1'b0;
            bcd_reg      <= '0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            shift_reg   <= {{BW{1'b0}}, bin};
            bit_cnt_reg <= CW'(WIDTH);
            ovf_reg     <= 1'b0;
        end else if (state_reg == SHIFT) begin
            shift_reg   <= shifted;
            bit_cnt_reg <= bit_cnt_reg - CW'(1);
            ovf_reg     <= ovf_next;
            // Publish the result on the final shift so it is already stable during the DONE strobe.
            if (last_bit) begin
                bcd_reg      <= shifted[SW-1:WIDTH];
                overflow_reg <= ovf_next;
            end
        end
    end

    assign bcd      = bcd_reg;
    assign overflow = overflow_reg;
endmodule
